// File: rtl/uart_improved_top.sv
// Full-duplex 8N1 UART: live-programmable 16x baud tick, RX/TX FSMs and first-word fall-through FIFOs.
// Build macro UART_LOOPBACK_EN feeds the internal tx line into the RX synchronizer instead of the rx pin.

module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] r_data,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [AW-1:0]            w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [AW-1:0]            w_ptr_nxt, r_ptr_nxt;
    logic                     full_q, full_d, empty_q, empty_d;
    logic                     push, pop;

    // A push into a full FIFO is accepted only when the same cycle frees a slot.
    assign pop       = rd & ~empty_q;
    assign push      = wr & (~full_q | pop);
    assign w_ptr_nxt = w_ptr_q + 1'b1;
    assign r_ptr_nxt = r_ptr_q + 1'b1;

    always_comb begin
        mem_d   = mem_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        if (push) mem_d[w_ptr_q] = w_data;
        case ({push, pop})
            2'b10: begin
                w_ptr_d = w_ptr_nxt;
                empty_d = 1'b0;
                full_d  = (w_ptr_nxt == r_ptr_q);
            end
            2'b01: begin
                r_ptr_d = r_ptr_nxt;
                full_d  = 1'b0;
                empty_d = (r_ptr_nxt == w_ptr_q);
            end
            2'b11: begin
                w_ptr_d = w_ptr_nxt;
                r_ptr_d = r_ptr_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign r_data = mem_q[r_ptr_q];
    assign empty  = empty_q;
    assign full   = full_q;
endmodule

module uart_baud (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] final_value,
    output logic        tick
);
    logic [10:0] cnt_q, cnt_d;

    // Terminal count is compared live so a new divisor applies at the next compare.
    always_comb begin
        tick  = (cnt_q == final_value);
        cnt_d = tick ? 11'd0 : cnt_q + 11'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            tick,
    output logic            rx_done,
    output logic [DBIT-1:0] dout
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        case (state_q)
            RX_IDLE: if (!rx) begin
                state_d = RX_START;
                s_d     = '0;
            end
            // Re-check the line near mid start bit; a short low pulse drops back to idle.
            RX_START: if (tick) begin
                if (s_q == S_MID) begin
                    s_d     = '0;
                    n_d     = '0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end else s_d = s_q + 1'b1;
            end
            RX_DATA: if (tick) begin
                if (s_q == S_BIT) begin
                    s_d = '0;
                    b_d = {rx, b_q[DBIT-1:1]};
                    if (n_q == N_LAST) state_d = RX_STOP;
                    else               n_d = n_q + 1'b1;
                end else s_d = s_q + 1'b1;
            end
            RX_STOP: if (tick) begin
                if (s_q == S_STOP) state_d = RX_IDLE;
                else               s_d = s_q + 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_done = (state_q == RX_STOP) && tick && (s_q == S_STOP);
        dout    = b_q;
    end
endmodule

module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            tx_empty,
    input  logic [DBIT-1:0] din,
    output logic            tx_pop,
    output logic            tx
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        case (state_q)
            TX_IDLE: if (tx_pop) begin
                state_d = TX_START;
                s_d     = '0;
                b_d     = din;
            end
            TX_START: if (tick) begin
                if (s_q == S_BIT) begin
                    state_d = TX_DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else s_d = s_q + 1'b1;
            end
            TX_DATA: if (tick) begin
                if (s_q == S_BIT) begin
                    s_d = '0;
                    b_d = b_q >> 1;
                    if (n_q == N_LAST) state_d = TX_STOP;
                    else               n_d = n_q + 1'b1;
                end else s_d = s_q + 1'b1;
            end
            // The last stop tick chains straight into the next start bit when data waits.
            TX_STOP: if (tick) begin
                if (s_q == S_STOP) begin
                    state_d = tx_pop ? TX_START : TX_IDLE;
                    s_d     = '0;
                    if (tx_pop) b_d = din;
                end else s_d = s_q + 1'b1;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Idle pops wait for a tick so every start bit spans a full 16 ticks.
    always_comb begin
        tx_pop = 1'b0;
        tx     = 1'b1;
        case (state_q)
            TX_IDLE:  tx_pop = tick & ~tx_empty;
            TX_START: tx = 1'b0;
            TX_DATA:  tx = b_q[0];
            TX_STOP:  tx_pop = tick & ~tx_empty & (s_q == S_STOP);
            default: ;
        endcase
    end
endmodule

module uart_improved_top #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [10:0]     TIMER_FINAL_VALUE,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr_uart,
    output logic            tx,
    output logic            tx_full
);
    // reset_n is active-high despite its name.
    logic            tick;
    logic            rx_src;
    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic            rx_done;
    logic [DBIT-1:0] rx_dout;
    logic            tx_pop, tx_empty, tx_int;
    logic [DBIT-1:0] tx_head;
    logic            rx_full_unused;

`ifdef UART_LOOPBACK_EN
    logic rx_pin_unused;
    assign rx_pin_unused = rx;
    assign rx_src        = tx_int;
`else
    assign rx_src = rx;
`endif

    always_comb begin
        sync1_d = rx_src;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    uart_baud u_baud (
        .clk(clk), .rst(reset_n), .final_value(TIMER_FINAL_VALUE), .tick(tick)
    );

    uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
        .clk(clk), .rst(reset_n), .rx(sync2_q), .tick(tick), .rx_done(rx_done), .dout(rx_dout)
    );

    uart_fifo #(.DW(DBIT), .AW(ADDR_WIDTH)) u_rx_fifo (
        .clk(clk), .rst(reset_n), .wr(rx_done), .rd(rd_uart), .w_data(rx_dout),
        .r_data(r_data), .empty(rx_empty), .full(rx_full_unused)
    );

    uart_fifo #(.DW(DBIT), .AW(ADDR_WIDTH)) u_tx_fifo (
        .clk(clk), .rst(reset_n), .wr(wr_uart), .rd(tx_pop), .w_data(w_data),
        .r_data(tx_head), .empty(tx_empty), .full(tx_full)
    );

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx (
        .clk(clk), .rst(reset_n), .tick(tick), .tx_empty(tx_empty), .din(tx_head),
        .tx_pop(tx_pop), .tx(tx_int)
    );

    assign tx = tx_int;
endmodule

// File: tb/tb_uart_improved_top.sv
// Self-checking bench for uart_improved_top: random bytes against a frame-level serial model.
module tb_uart_improved_top;
    localparam int BITC  = 64;
    localparam int FRAME = 10 * BITC;

    logic        clk = 1'b0;
    logic        reset_n, rx, rd_uart, wr_uart;
    logic [10:0] tfv;
    logic [7:0]  r_data, w_data;
    logic        rx_empty, tx, tx_full;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_improved_top #(.DBIT(8), .SB_TICK(16), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .TIMER_FINAL_VALUE(tfv), .rx(rx),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .w_data(w_data), .wr_uart(wr_uart), .tx(tx), .tx_full(tx_full)
    );

    // Ideal line waveform of one frame, one entry per clock starting at the start-bit edge.
    function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
        logic [FRAME-1:0] w;
        for (int k = 0; k < FRAME; k++) begin
            if (k < BITC)           w[k] = 1'b0;
            else if (k < 9 * BITC)  w[k] = b[(k - BITC) / BITC];
            else                    w[k] = 1'b1;
        end
        return w;
    endfunction

    function automatic int first_diff(input logic [FRAME-1:0] a, input logic [FRAME-1:0] b);
        for (int k = 0; k < FRAME; k++) if (a[k] !== b[k]) return k;
        return -1;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b1; wr_uart = 1'b0; rd_uart = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] b);
        @(negedge clk);
        w_data = b; wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic pop_word;
        @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    // Records one tx frame from its falling edge; reports a timeout instead of hanging.
    task automatic rec_tx(input int budget, output logic [FRAME-1:0] w, output int t_fall,
                          output logic full_at_fall, output bit to);
        int n;
        n = 0; w = '1; t_fall = 0; to = 1'b0; full_at_fall = 1'bx;
        @(negedge clk);
        while (tx !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        if (tx !== 1'b0) begin to = 1'b1; return; end
        t_fall = cyc;
        full_at_fall = tx_full;
        for (int k = 0; k < FRAME; k++) begin
            w[k] = tx;
            if (k < FRAME - 1) @(negedge clk);
        end
    endtask

    task automatic drive_rx_bits(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge clk);
        end
    endtask

    task automatic drive_rx_stop;
        rx = 1'b1;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic test_reset;
        int n, t0, per;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || rx_empty !== 1'b1 || tx_full !== 1'b0 || r_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state tx=%b rx_empty=%b tx_full=%b r_data=%h want 1 1 0 00",
                     tx, rx_empty, tx_full, r_data);
        end
        reset_n = 1'b0;
        n = 0;
        @(negedge clk);
        while (dut.tick !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        @(negedge clk);
        while (dut.tick !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        per = cyc - t0;
        checks++;
        if (per != 4) begin
            errors++;
            $display("FAIL tick_period got=%0d want=4", per);
        end
        pop_word;
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_when_empty rx_empty=%b want 1", rx_empty);
        end
    endtask

    task automatic test_tx_frame;
        logic [7:0]       bytes[4];
        logic [FRAME-1:0] w;
        int               tf, d, hi;
        logic             ff;
        bit               to;
        do_reset;
        bytes[0] = 8'hA5;
        for (int i = 1; i < 4; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            push_word(bytes[i]);
            rec_tx(200, w, tf, ff, to);
            d = first_diff(w, frame_wave(bytes[i]));
            checks++;
            if (to || d >= 0) begin
                errors++;
                $display("FAIL tx_frame byte=%h timeout=%0d first_bad_clk=%0d got=%b want=%b",
                         bytes[i], to, d, (d >= 0) ? w[d] : 1'b0, (d >= 0) ? ~w[d] : 1'b0);
            end
            hi = 0;
            for (int k = 0; k < BITC; k++) begin
                @(negedge clk);
                if (tx === 1'b1) hi++;
            end
            checks++;
            if (hi != BITC) begin
                errors++;
                $display("FAIL tx_idle_after byte=%h high_clks=%0d want=%0d", bytes[i], hi, BITC);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]       sent_q[$];
        logic [7:0]       wb, exp_b;
        logic [FRAME-1:0] caps[5];
        int               tfs[5];
        logic             ffs[5];
        bit               tos[5];
        int               d, lows;
        do_reset;
        wb = 8'($urandom);
        sent_q.push_back(wb);
        push_word(wb);
        fork
            begin
                int n, depth;
                n = 0; depth = 0;
                while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
                for (int i = 0; i < 5; i++) begin
                    wb = 8'($urandom);
                    w_data = wb; wr_uart = 1'b1;
                    if (depth < 4) begin sent_q.push_back(wb); depth++; end
                    @(negedge clk);
                end
                wr_uart = 1'b0;
                checks++;
                if (tx_full !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_full_after_5 got=%b want=1", tx_full);
                end
            end
            begin
                for (int f = 0; f < 5; f++) rec_tx(1500, caps[f], tfs[f], ffs[f], tos[f]);
            end
        join
        for (int f = 0; f < 5; f++) begin
            exp_b = sent_q[f];
            d = first_diff(caps[f], frame_wave(exp_b));
            checks++;
            if (tos[f] || d >= 0) begin
                errors++;
                $display("FAIL b2b_frame idx=%0d timeout=%0d first_bad_clk=%0d want_byte=%h",
                         f, tos[f], d, exp_b);
            end
            if (f > 0) begin
                checks++;
                if (tfs[f] - tfs[f-1] != FRAME) begin
                    errors++;
                    $display("FAIL b2b_gap idx=%0d got=%0d want=%0d", f, tfs[f] - tfs[f-1], FRAME);
                end
            end
        end
        checks++;
        if (ffs[1] !== 1'b0) begin
            errors++;
            $display("FAIL tx_full_release got=%b want=0", ffs[1]);
        end
        lows = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL b2b_extra_frame low_clks=%0d want=0", lows);
        end
    endtask

    task automatic test_reset_mid_frame;
        int lows;
        do_reset;
        push_word(8'h00);
        repeat (150) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_full !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset tx=%b tx_full=%b want 1 0", tx, tx_full);
        end
        @(negedge clk);
        reset_n = 1'b0;
        lows = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL after_reset_idle low_clks=%0d want=0", lows);
        end
    endtask

`ifndef UART_LOOPBACK_EN
    task automatic test_rx;
        logic [7:0] q[$];
        logic [7:0] b, e;
        do_reset;
        drive_rx_bits(8'h3C);
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL rx_early rx_empty=%b want 1 before stop bit", rx_empty);
        end
        drive_rx_stop;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_empty !== 1'b0 || r_data !== 8'h3C) begin
            errors++;
            $display("FAIL rx_3c rx_empty=%b r_data=%h want 0 3c", rx_empty, r_data);
        end
        pop_word;
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL rx_pop rx_empty=%b want 1", rx_empty);
        end
        // Five frames into a four-deep FIFO with no reads: the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            drive_rx_bits(b);
            drive_rx_stop;
            if (q.size() < 4) q.push_back(b);
        end
        repeat (4) @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (rx_empty !== 1'b0 || r_data !== e) begin
                errors++;
                $display("FAIL rx_rand rx_empty=%b r_data=%h want 0 %h", rx_empty, r_data, e);
            end
            pop_word;
        end
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL rx_overflow_drop rx_empty=%b want 1", rx_empty);
        end
    endtask

    task automatic test_glitch;
        do_reset;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (700) @(negedge clk);
        checks++;
        if (rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL rx_glitch rx_empty=%b want 1", rx_empty);
        end
    endtask
`else
    task automatic test_loopback;
        logic [7:0] b[2];
        b[0] = 8'h5A;
        b[1] = 8'($urandom);
        do_reset;
        rx = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_word(b[i]);
            repeat (800) @(negedge clk);
            checks++;
            if (rx_empty !== 1'b0 || r_data !== b[i]) begin
                errors++;
                $display("FAIL loopback rx_empty=%b r_data=%h want 0 %h", rx_empty, r_data, b[i]);
            end
            pop_word;
        end
        rx = 1'b1;
    endtask
`endif

    initial begin
        reset_n = 1'b1; rx = 1'b1; rd_uart = 1'b0; wr_uart = 1'b0;
        w_data = 8'h00; tfv = 11'd3;
        test_reset;
        test_tx_frame;
        test_back_to_back;
        test_reset_mid_frame;
`ifndef UART_LOOPBACK_EN
        test_rx;
        test_glitch;
`else
        test_loopback;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
